weight_update_seq: RTL and testbench
====================================

# weight_update_seq

Sequencer that drives the GMM weight-update engine over a full frame of per-pixel weight triples. For each pixel it reads three FP32 weights and a match index from the background-model memories, presents them to the weight-update engine with a one-cycle enable, holds the operands stable until the engine's ready strobe, then writes the normalised weights back to the same address. It is the initiator side of the engine's `en_updateWeight`/`rd_updateWeight` handshake and sits between the frame controller and the per-pixel update datapath.

## Interface
- `ADDR_W`, 17: pixel address width.
- `NUM_PIXELS`, 76800: pixels per frame (320x240); the last address is `NUM_PIXELS-1`.
- `TIMEOUT`, 255: maximum WAIT cycles allowed before the engine is declared hung.
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: frame start pulse; ignored unless in IDLE.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle pulse after the last pixel's write.
- `err_o` out 1: sticky timeout flag; cleared by the next accepted `start_i`.
- `mem_re_o` out 1: read enable for the weight and match memories.
- `mem_raddr_o` out ADDR_W: read address.
- `mem_rdata_i` in 96: weights; [31:0]=w0, [63:32]=w1, [95:64]=w2. Valid one cycle after `mem_re_o`.
- `match_num_i` in 2: match index (0/1/2 = model matched, 3 = no match). Same one-cycle latency.
- `mem_we_o` out 1: write strobe.
- `mem_waddr_o` out ADDR_W: write address.
- `mem_wdata_o` out 96: write data, same packing as `mem_rdata_i`.
- `uw_w0_o`, `uw_w1_o`, `uw_w2_o` out 32 each: engine operands.
- `uw_num_o` out 2: engine match index.
- `uw_en_o` out 1: engine enable, exactly one cycle per pixel.
- `uw_w0_i`, `uw_w1_i`, `uw_w2_i` in 32 each: engine results.
- `uw_rd_i` in 1: engine ready strobe; results are valid in the cycle it is high.

## Operation
- States: IDLE, READ, LATCH, FIRE, WAIT, WRITE, DONE.
- IDLE → READ on `start_i`. Address counter is set to 0 and `err_o` is cleared.
- READ: `mem_re_o`=1 and `mem_raddr_o`=addr, for one cycle. → LATCH.
- LATCH: registers `mem_rdata_i` and `match_num_i` into the operand registers that drive `uw_*_o`. → FIRE.
- FIRE: `uw_en_o`=1 for one cycle. The WAIT counter is cleared. → WAIT.
- WAIT: the operand registers and `uw_num_o` are held unchanged. The engine re-samples them combinationally until its result strobe, so they must not move.
  - On `uw_rd_i`=1: capture the three engine results into the write-data register. → WRITE.
  - Otherwise, when the counter reaches TIMEOUT: set `err_o`, no write, no `done_o`. → IDLE.
- WRITE: `mem_we_o`=1 for one cycle, with `mem_waddr_o`=addr and `mem_wdata_o` = {w2, w1, w0} results.
  - If addr = NUM_PIXELS-1 → DONE.
  - Otherwise addr increments → READ.
- DONE: `done_o`=1 for one cycle. → IDLE.
- `uw_rd_i` outside WAIT is ignored. A strobe in the same cycle as `uw_en_o` is also ignored.
- `start_i` while busy is ignored and has no effect on addr or `err_o`.
- `match_num_i` = 3 is passed through unchanged; the engine handles the no-match case.
- The address counter never exceeds NUM_PIXELS-1; there is no wrap within a frame.

## Timing
- Reset values: all outputs 0, state IDLE, addr 0, operand and write-data registers 0.
- Reset asserted mid-frame aborts immediately: no further write or `done_o`. After release the block sits in IDLE.
- Engine latency L is the number of cycles from the `uw_en_o` cycle to the `uw_rd_i` cycle.
- Per-pixel period is L + 4 cycles: READ, LATCH, FIRE, WRITE, plus L cycles of WAIT.
- `start_i` at cycle 0 puts READ at cycle 1 and FIRE at cycle 3.
- `done_o` is asserted in the cycle after the last WRITE.
- The timeout fires on the cycle the counter equals TIMEOUT, where the counter is 1 on the first WAIT cycle without a strobe.
  - A strobe on that same cycle wins: no error, proceed to WRITE.

## Test plan
- NUM_PIXELS=4, engine model with L=10 that returns inputs ×0.5. Memory words {0x3F800000, 0x40000000, 0x40400000} → four writes of {0x3FC00000, 0x3F800000, 0x3F000000}. Addresses 0..3, writes spaced 14 cycles apart, `done_o` once, `busy_o` low afterwards.
- Model asserts `uw_rd_i` with per-pixel varying L (1, 7, 30). Check that `uw_*_o` and `uw_num_o` stay constant from FIRE to strobe, and that exactly one `uw_en_o` is issued per pixel.
- Model never responds, TIMEOUT=8. Expect `err_o`=1 and return to IDLE on the 8th WAIT cycle, no `mem_we_o`. A new `start_i` clears `err_o` and the frame then completes normally.
- `start_i` pulsed during WAIT and a spurious `uw_rd_i` during READ/LATCH → no state, address, or write change.
- `rst_i` low during pixel 2's WAIT → all outputs 0 at once. After release there is no write until the next `start_i`, and that frame restarts at address 0.
- `match_num_i` sequence 0, 1, 2, 3 across the four pixels → `uw_num_o` matches per pixel and the written data equals the model output.

Source files
------------

// File: rtl/weight_update_seq.sv
// rtl/weight_update_seq.sv - frame sequencer for the GMM weight-update engine handshake
module weight_update_seq #(
    parameter int ADDR_W     = 17,
    parameter int NUM_PIXELS = 76800,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [95:0]       mem_rdata_i,
    input  logic [1:0]        match_num_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [95:0]       mem_wdata_o,
    output logic [31:0]       uw_w0_o,
    output logic [31:0]       uw_w1_o,
    output logic [31:0]       uw_w2_o,
    output logic [1:0]        uw_num_o,
    output logic              uw_en_o,
    input  logic [31:0]       uw_w0_i,
    input  logic [31:0]       uw_w1_i,
    input  logic [31:0]       uw_w2_i,
    input  logic              uw_rd_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_FIRE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_nxt;

    // The same pixel address serves the read and the later write-back
    assign mem_raddr_o = addr;
    assign mem_waddr_o = addr;
    // Count value for the current WAIT cycle: 1 on the first WAIT cycle
    assign wait_nxt    = wait_cnt + CNT_W'(1);

    // Sequencer: one pixel per pass, strobes are registered and last one cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            addr        <= '0;
            wait_cnt    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            uw_w0_o     <= '0;
            uw_w1_o     <= '0;
            uw_w2_o     <= '0;
            uw_num_o    <= '0;
            uw_en_o     <= 1'b0;
        end else begin
            mem_re_o <= 1'b0;
            mem_we_o <= 1'b0;
            uw_en_o  <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state    <= S_READ;
                        addr     <= '0;
                        err_o    <= 1'b0;
                        busy_o   <= 1'b1;
                        mem_re_o <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    // Operands stay frozen from here until the engine answers
                    uw_w0_o  <= mem_rdata_i[31:0];
                    uw_w1_o  <= mem_rdata_i[63:32];
                    uw_w2_o  <= mem_rdata_i[95:64];
                    uw_num_o <= match_num_i;
                    uw_en_o  <= 1'b1;
                    state    <= S_FIRE;
                end
                S_FIRE: begin
                    // A ready strobe in the enable cycle is not looked at
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (uw_rd_i) begin
                        mem_wdata_o <= {uw_w2_i, uw_w1_i, uw_w0_i};
                        mem_we_o    <= 1'b1;
                        state       <= S_WRITE;
                    end else if (wait_nxt == TIMEOUT_CNT) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                S_WRITE: begin
                    if (addr == LAST_ADDR) begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        addr     <= addr + ADDR_W'(1);
                        mem_re_o <= 1'b1;
                        state    <= S_READ;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_update_seq.sv
// tb/tb_weight_update_seq.sv - bench for weight_update_seq with memory, engine and schedule models
module tb_weight_update_seq;

    localparam int ADDR_W = 17;
    localparam int NP     = 4;
    localparam int TO     = 32;

    logic              clk_i   = 1'b0;
    logic              rst_i   = 1'b1;
    logic              start_i = 1'b0;
    logic              busy_o, done_o, err_o, mem_re_o, mem_we_o, uw_en_o;
    logic [ADDR_W-1:0] mem_raddr_o, mem_waddr_o;
    logic [95:0]       mem_wdata_o;
    logic [31:0]       uw_w0_o, uw_w1_o, uw_w2_o;
    logic [1:0]        uw_num_o;
    logic [95:0]       mem_rdata_i = '0;
    logic [1:0]        match_num_i = '0;
    logic [31:0]       uw_w0_i = '0, uw_w1_i = '0, uw_w2_i = '0;
    logic              eng_rd = 1'b0, spur_rd = 1'b0;
    logic              uw_rd_i;

    assign uw_rd_i = eng_rd | spur_rd;

    weight_update_seq #(.ADDR_W(ADDR_W), .NUM_PIXELS(NP), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
        .mem_rdata_i(mem_rdata_i), .match_num_i(match_num_i),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .uw_w0_o(uw_w0_o), .uw_w1_o(uw_w1_o), .uw_w2_o(uw_w2_o),
        .uw_num_o(uw_num_o), .uw_en_o(uw_en_o),
        .uw_w0_i(uw_w0_i), .uw_w1_i(uw_w1_i), .uw_w2_i(uw_w2_i), .uw_rd_i(uw_rd_i)
    );

    always #5 clk_i = ~clk_i;

    logic [95:0] mem_data [NP];
    logic [1:0]  mem_match[NP];
    int          lat_tab  [NP];
    int          read_cyc [NP];
    int          fire_cyc [NP];

    int cyc = 0;
    bit armed = 1'b0;
    int rd_at = 0;
    int n_en = 0, n_done = 0;
    int wr_cyc[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [95:0]       wr_data[$];

    bit                exp_re   [int];
    logic [ADDR_W-1:0] exp_raddr[int];
    bit                exp_en   [int];
    bit                exp_we   [int];
    logic [ADDR_W-1:0] exp_waddr[int];
    logic [95:0]       exp_wdata[int];
    bit                exp_done [int];
    int                exp_op   [int];
    bit                err_chg  [int];
    bit                exp_err = 1'b0;
    int                busy_lo = 1, busy_hi = 0;

    int n_checks = 0, n_pass = 0;

    function automatic logic [31:0] half(input logic [31:0] x);
        return x - 32'h0080_0000;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    endtask

    // Memory, engine (x0.5 after a per-pixel latency) and write/done recorders
    always @(posedge clk_i) begin
        if (mem_re_o) begin
            mem_rdata_i <= mem_data[mem_raddr_o[1:0]];
            match_num_i <= mem_match[mem_raddr_o[1:0]];
        end
        if (uw_en_o) begin
            n_en++;
            if (lat_tab[mem_raddr_o[1:0]] > 0) begin
                armed = 1'b1;
                rd_at = cyc + lat_tab[mem_raddr_o[1:0]];
            end
        end
        if (!rst_i) armed = 1'b0;
        if (armed && cyc + 1 == rd_at) begin
            eng_rd <= 1'b1;
            armed = 1'b0;
        end else begin
            eng_rd <= 1'b0;
        end
        uw_w0_i <= half(uw_w0_o);
        uw_w1_i <= half(uw_w1_o);
        uw_w2_i <= half(uw_w2_o);
        if (mem_we_o) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(mem_waddr_o);
            wr_data.push_back(mem_wdata_o);
        end
        if (done_o) n_done++;
        cyc = cyc + 1;
    end

    // Per-cycle comparison against the expected schedule
    always @(negedge clk_i) begin
        if (err_chg.exists(cyc)) exp_err = err_chg[cyc];
        chk("mem_re", mem_re_o, exp_re.exists(cyc));
        if (exp_re.exists(cyc)) chk("raddr", mem_raddr_o, exp_raddr[cyc]);
        chk("uw_en", uw_en_o, exp_en.exists(cyc));
        chk("mem_we", mem_we_o, exp_we.exists(cyc));
        if (exp_we.exists(cyc)) begin
            chk("waddr", mem_waddr_o, exp_waddr[cyc]);
            chk("wdata", mem_wdata_o, exp_wdata[cyc]);
        end
        chk("done", done_o, exp_done.exists(cyc));
        chk("busy", busy_o, (cyc >= busy_lo) && (cyc <= busy_hi));
        chk("err", err_o, exp_err);
        if (exp_op.exists(cyc)) begin
            chk("operands", {uw_w2_o, uw_w1_o, uw_w0_o}, mem_data[exp_op[cyc]]);
            chk("uw_num", uw_num_o, mem_match[exp_op[cyc]]);
        end
        if (!rst_i)
            chk("reset_data_zero", |{mem_raddr_o, mem_waddr_o, mem_wdata_o,
                                     uw_w0_o, uw_w1_o, uw_w2_o, uw_num_o}, 1'b0);
    end

    // Pixel i: READ, LATCH, FIRE, L WAIT cycles, WRITE; timeout on WAIT cycle TO
    task automatic plan_frame(input int s);
        int r, f, w;
        r = s + 1;
        busy_lo = s + 1;
        err_chg[s + 1] = 1'b0;
        for (int i = 0; i < NP; i++) begin
            exp_re[r] = 1'b1;
            exp_raddr[r] = ADDR_W'(i);
            read_cyc[i] = r;
            f = r + 2;
            fire_cyc[i] = f;
            exp_en[f] = 1'b1;
            if (lat_tab[i] == 0 || lat_tab[i] > TO) begin
                for (int c = f; c <= f + TO; c++) exp_op[c] = i;
                err_chg[f + TO + 1] = 1'b1;
                busy_hi = f + TO;
                return;
            end
            for (int c = f; c <= f + lat_tab[i]; c++) exp_op[c] = i;
            w = f + lat_tab[i] + 1;
            exp_we[w] = 1'b1;
            exp_waddr[w] = ADDR_W'(i);
            exp_wdata[w] = {half(mem_data[i][95:64]), half(mem_data[i][63:32]), half(mem_data[i][31:0])};
            r = w + 1;
        end
        exp_done[r] = 1'b1;
        busy_hi = r;
    endtask

    task automatic flush_model();
        exp_re.delete(); exp_raddr.delete(); exp_en.delete(); exp_we.delete();
        exp_waddr.delete(); exp_wdata.delete(); exp_done.delete(); exp_op.delete();
        err_chg.delete();
        exp_err = 1'b0;
        busy_lo = 0;
        busy_hi = -1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start_frame(output int s);
        s = cyc;
        start_i = 1'b1;
        plan_frame(s);
        at_cycle(s + 1);
        start_i = 1'b0;
    endtask

    initial begin
        int s, wb, db, eb, k;
        #1 rst_i = 1'b0;
        at_cycle(3);
        chk("reset_ctrl_zero", {busy_o, done_o, err_o, mem_re_o, mem_we_o, uw_en_o}, 6'd0);
        rst_i = 1'b1;
        at_cycle(5);

        // Frame A: constant weights, L=10, match 0..3
        for (int i = 0; i < NP; i++) begin
            mem_data[i]  = {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
            mem_match[i] = 2'(i);
            lat_tab[i]   = 10;
        end
        wb = wr_cyc.size(); db = n_done;
        start_frame(s);
        k = 0;
        while (!done_o && k < 300) begin
            at_cycle(cyc + 1);
            k++;
        end
        chk("frameA_done_seen", done_o, 1'b1);
        at_cycle(cyc + 3);
        chk("frameA_writes", wr_cyc.size() - wb, 4);
        if (wr_cyc.size() - wb == 4) begin
            for (int i = 0; i < NP; i++) begin
                chk("frameA_addr", wr_addr[wb + i], i);
                chk("frameA_data", wr_data[wb + i], 96'h3FC00000_3F800000_3F000000);
            end
            for (int i = 0; i < NP - 1; i++)
                chk("frameA_spacing", wr_cyc[wb + i + 1] - wr_cyc[wb + i], 14);
        end
        chk("frameA_done_count", n_done - db, 1);
        chk("frameA_idle", busy_o, 1'b0);

        // Frame B: varying latency incl. strobe on the timeout cycle, spurious inputs
        lat_tab = '{1, 7, 30, TO};
        for (int i = 0; i < NP; i++) begin
            mem_data[i]  = {32'h4110_0000 + 32'(i << 21), 32'h40A0_0000 + 32'(i << 20), 32'h3FC0_0000 + 32'(i << 19)};
            mem_match[i] = 2'(3 - i);
        end
        wb = wr_cyc.size(); db = n_done; eb = n_en;
        start_frame(s);
        at_cycle(read_cyc[1]);      spur_rd = 1'b1;
        at_cycle(read_cyc[1] + 2);  spur_rd = 1'b0;
        at_cycle(fire_cyc[2] + 5);  start_i = 1'b1;
        at_cycle(fire_cyc[2] + 6);  start_i = 1'b0;
        at_cycle(fire_cyc[3]);      spur_rd = 1'b1;
        at_cycle(fire_cyc[3] + 1);  spur_rd = 1'b0;
        at_cycle(busy_hi + 3);
        chk("frameB_en_count", n_en - eb, 4);
        chk("frameB_writes", wr_cyc.size() - wb, 4);
        chk("frameB_done_count", n_done - db, 1);

        // Frame C: engine hangs on pixel 1
        lat_tab = '{10, 0, 10, 10};
        wb = wr_cyc.size(); db = n_done;
        start_frame(s);
        at_cycle(busy_hi + 3);
        chk("frameC_err", err_o, 1'b1);
        chk("frameC_writes", wr_cyc.size() - wb, 1);
        chk("frameC_no_done", n_done - db, 0);
        chk("frameC_idle", busy_o, 1'b0);

        // Frame D: restart clears the error and completes
        lat_tab = '{5, 5, 5, 5};
        wb = wr_cyc.size(); db = n_done;
        start_frame(s);
        chk("frameD_err_cleared", err_o, 1'b0);
        at_cycle(busy_hi + 3);
        chk("frameD_writes", wr_cyc.size() - wb, 4);
        chk("frameD_done_count", n_done - db, 1);

        // Frame E: reset during pixel 2's WAIT
        lat_tab = '{10, 10, 10, 10};
        start_frame(s);
        at_cycle(fire_cyc[2] + 3);
        #1 rst_i = 1'b0;
        flush_model();
        #1;
        chk("reset_async_zero", |{busy_o, done_o, err_o, mem_re_o, mem_we_o, uw_en_o,
                                  mem_raddr_o, mem_waddr_o, mem_wdata_o,
                                  uw_w0_o, uw_w1_o, uw_w2_o, uw_num_o}, 1'b0);
        at_cycle(cyc + 3);
        rst_i = 1'b1;
        wb = wr_cyc.size();
        at_cycle(cyc + 20);
        chk("post_reset_no_write", wr_cyc.size() - wb, 0);
        chk("post_reset_idle", busy_o, 1'b0);

        // Frame F: restarts at address 0
        db = n_done;
        start_frame(s);
        at_cycle(busy_hi + 3);
        chk("frameF_writes", wr_cyc.size() - wb, 4);
        if (wr_cyc.size() > wb) chk("frameF_first_addr", wr_addr[wb], 0);
        chk("frameF_done_count", n_done - db, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
